piso_serializer: RTL and testbench

- Parametrised parallel-in/serial-out serializer, successor to the fixed 8-bit serial-out/done block.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock, in a configurable bit order.
- Can append an optional parity bit to each frame.
- A one-entry holding buffer allows back-to-back frames with no idle gap. Sits between the stimulus/data source and a serial consumer that samples on done.

---
 rtl/piso_serializer.sv | 154 +++++++++++++++
 tb/tb_piso_serializer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module   : piso_serializer
// Purpose  : WIDTH-bit parallel-in/serial-out shifter with a valid/ready input,
//            an optional parity bit and a one-word holding buffer.
// Revision : 1.0  initial release
// ============================================================================
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int PARITY    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] Input,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             Out,
  output logic             out_valid,
  output logic             done,
  output logic             busy
);

  localparam int c_frame_len = WIDTH + ((PARITY != 0) ? 1 : 0);
  localparam int c_cnt_w     = $clog2(c_frame_len + 1);
  localparam logic [c_cnt_w-1:0] c_last_data = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
  localparam logic c_has_par = (PARITY != 0);
  localparam logic c_odd_par = (PARITY == 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   buf_q, buf_d;
  logic               buf_full_q, buf_full_d;
  logic               par_q, par_d;
  logic               out_q, out_d;

  logic             w_xfer;
  logic             w_end;
  logic             w_load;
  logic [WIDTH-1:0] w_load_word;
  logic             w_load_bit;
  logic [WIDTH-1:0] w_load_rest;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_next_rest;

  // in_ready depends only on state, never on in_valid
  assign in_ready  = rst && !buf_full_q;
  assign w_xfer    = in_valid && in_ready;
  assign w_end     = ((state_q == SHIFT) && (cnt_q == c_last_data) && !c_has_par) ||
                     (state_q == PAR);
  // a buffered word always has priority; otherwise an input can go straight in
  assign w_load    = ((state_q == IDLE) && w_xfer) ||
                     (w_end && (buf_full_q || w_xfer));
  assign w_load_word = buf_full_q ? buf_q : Input;

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_load_bit  = w_load_word[WIDTH-1];
      assign w_load_rest = {w_load_word[WIDTH-2:0], 1'b0};
      assign w_next_bit  = shift_q[WIDTH-1];
      assign w_next_rest = {shift_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_load_bit  = w_load_word[0];
      assign w_load_rest = {1'b0, w_load_word[WIDTH-1:1]};
      assign w_next_bit  = shift_q[0];
      assign w_next_rest = {1'b0, shift_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    par_d      = par_q;
    out_d      = out_q;

    case (state_q)
      IDLE: begin
        if (!w_load) state_d = IDLE;
      end
      SHIFT: begin
        if (cnt_q != c_last_data) begin
          out_d   = w_next_bit;
          shift_d = w_next_rest;
          cnt_d   = cnt_q + c_cnt_one;
        end else if (c_has_par) begin
          state_d = PAR;
          out_d   = par_q;
          cnt_d   = cnt_q + c_cnt_one;
        end else begin
          state_d = IDLE;
        end
      end
      PAR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // loading overrides the end-of-frame return to IDLE
    if (w_load) begin
      state_d = SHIFT;
      out_d   = w_load_bit;
      shift_d = w_load_rest;
      cnt_d   = '0;
      par_d   = (^w_load_word) ^ c_odd_par;
      if (buf_full_q) buf_full_d = 1'b0;
    end

    if (w_xfer && !w_load) begin
      buf_d      = Input;
      buf_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      par_q      <= 1'b0;
      out_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      par_q      <= par_d;
      out_q      <= out_d;
    end
  end

  assign Out       = out_q;
  assign out_valid = (state_q != IDLE);
  assign done      = w_end;
  assign busy      = (state_q != IDLE) || buf_full_q;

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_serializer
// Purpose  : Self-checking bench for four piso_serializer configurations.
// Revision : 1.0  initial release
// ============================================================================
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din [4];
  logic [3:0] vld = 4'h0;
  wire  [3:0] rdy, sout, oval, dn, bsy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] tw [4];
  logic [8:0] te [4];

  logic [7:0] expq [4][$];
  logic [8:0] col  [4];
  int         ncol [4];
  int         ndone[4];
  logic       mon_en = 1'b0;

  always #5 clk = ~clk;

  // instance 0: MSB/no parity, 1: LSB/no parity, 2: MSB/even, 3: LSB/odd
  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_dut
      piso_serializer #(
        .WIDTH    (8),
        .MSB_FIRST((g == 1 || g == 3) ? 0 : 1),
        .PARITY   ((g >= 2) ? (g - 1) : 0)
      ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .Input    (din[g]),
        .in_valid (vld[g]),
        .in_ready (rdy[g]),
        .Out      (sout[g]),
        .out_valid(oval[g]),
        .done     (dn[g]),
        .busy     (bsy[g])
      );
    end
  endgenerate

  function automatic int cfg_msb(input int i);
    return (i == 1 || i == 3) ? 0 : 1;
  endfunction

  function automatic int cfg_par(input int i);
    return (i >= 2) ? (i - 1) : 0;
  endfunction

  function automatic int cfg_len(input int i);
    return (cfg_par(i) != 0) ? 9 : 8;
  endfunction

  // frame bits in time order, first bit in the highest used position
  function automatic logic [8:0] exp_frame(input int i, input logic [7:0] w);
    logic [7:0] o;
    logic       p;
    for (int k = 0; k < 8; k++) o[7-k] = (cfg_msb(i) != 0) ? w[7-k] : w[k];
    if (cfg_par(i) == 0) return {1'b0, o};
    p = (^w) ^ (cfg_par(i) == 2);
    return {o, p};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // all four instances load tw[] at once; te[] holds hand-computed frames
  task automatic run_frames(input string tag);
    int len;
    for (int i = 0; i < 4; i++) din[i] = tw[i];
    vld = 4'hF;
    for (int i = 0; i < 4; i++) check_eq($sformatf("%s rdy i%0d", tag, i), rdy[i], 1);
    tick();
    vld = 4'h0;
    for (int c = 1; c <= 10; c++) begin
      for (int i = 0; i < 4; i++) begin
        len = cfg_len(i);
        check_eq($sformatf("%s ov i%0d c%0d", tag, i, c), oval[i], (c <= len));
        check_eq($sformatf("%s out i%0d c%0d", tag, i, c), sout[i],
                 (c <= len) ? te[i][len-c] : te[i][0]);
        check_eq($sformatf("%s done i%0d c%0d", tag, i, c), dn[i], (c == len));
        check_eq($sformatf("%s busy i%0d c%0d", tag, i, c), bsy[i], (c <= len));
      end
      tick();
    end
  endtask

  task automatic wait_accept(input int i);
    int  guard;
    logic ok;
    guard = 0;
    ok    = 1'b0;
    while (!ok && guard < 40) begin
      ok = rdy[i];
      tick();
      guard++;
    end
    check_eq($sformatf("accept i%0d", i), ok, 1);
  endtask

  task automatic drive_rand(input int i);
    int gap;
    for (int n = 0; n < 50; n++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) tick();
      din[i]  = 8'($urandom);
      vld[i]  = 1'b1;
      wait_accept(i);
      vld[i]  = 1'b0;
    end
  endtask

  // scoreboard: words queued on transfer, frames rebuilt from out_valid bits
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 4; i++) begin
        logic [7:0] w;
        logic [8:0] got;
        int         pend;
        if (vld[i] && rdy[i]) expq[i].push_back(din[i]);
        if (oval[i]) begin
          col[i]  = {col[i][7:0], sout[i]};
          ncol[i] = ncol[i] + 1;
        end
        if (dn[i]) begin
          ndone[i] = ndone[i] + 1;
          pend = expq[i].size();
          w    = (pend > 0) ? expq[i].pop_front() : 8'h00;
          got  = (cfg_len(i) == 8) ? {1'b0, col[i][7:0]} : col[i];
          check_eq($sformatf("sb pend i%0d", i), (pend > 0), 1);
          check_eq($sformatf("sb len i%0d", i), ncol[i], cfg_len(i));
          check_eq($sformatf("sb frame i%0d w%0h", i, w), got, exp_frame(i, w));
          col[i]  = '0;
          ncol[i] = 0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] b2b;
    for (int i = 0; i < 4; i++) begin
      din[i] = 8'h00; col[i] = '0; ncol[i] = 0; ndone[i] = 0;
    end
    void'($urandom(32'h5EED_0001));

    // reset values while rst is low
    #10;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("rst out i%0d", i), sout[i], 0);
      check_eq($sformatf("rst ov i%0d", i), oval[i], 0);
      check_eq($sformatf("rst done i%0d", i), dn[i], 0);
      check_eq($sformatf("rst busy i%0d", i), bsy[i], 0);
      check_eq($sformatf("rst rdy i%0d", i), rdy[i], 0);
    end
    #12 rst = 1'b1;
    tick();

    // 0xA5 into every configuration
    for (int i = 0; i < 4; i++) tw[i] = 8'hA5;
    te[0] = 9'b0_1010_0101;
    te[1] = 9'b0_1010_0101;
    te[2] = 9'b1_0100_1010;
    te[3] = 9'b1_0100_1011;
    run_frames("a5");

    // 0x01 / 0x07 with bit order and parity differences
    tw[0] = 8'h01; tw[1] = 8'h01; tw[2] = 8'h07; tw[3] = 8'h07;
    te[0] = 9'b0_0000_0001;
    te[1] = 9'b0_1000_0000;
    te[2] = 9'b0_0000_1111;
    te[3] = 9'b1_1100_0000;
    run_frames("w01");

    // back-to-back on instance 0: 0x0F then 0xF0 via the buffer
    b2b = 16'b0000_1111_1111_0000;
    din[0] = 8'h0F;
    vld[0] = 1'b1;
    tick();
    din[0] = 8'hF0;
    check_eq("b2b rdy c1", rdy[0], 1);
    check_eq("b2b out c1", sout[0], b2b[15]);
    tick();
    vld[0] = 1'b0;
    for (int c = 2; c <= 17; c++) begin
      check_eq($sformatf("b2b ov c%0d", c), oval[0], (c <= 16));
      if (c <= 16) check_eq($sformatf("b2b out c%0d", c), sout[0], b2b[16-c]);
      check_eq($sformatf("b2b done c%0d", c), dn[0], (c == 8 || c == 16));
      check_eq($sformatf("b2b rdy c%0d", c), rdy[0], (c >= 9));
      tick();
    end
    check_eq("b2b idle busy", bsy[0], 0);

    // reset while 0x3C is shifting and 0x55 is buffered
    din[0] = 8'h3C;
    vld[0] = 1'b1;
    tick();
    din[0] = 8'h55;
    tick();
    vld[0] = 1'b0;
    check_eq("abort buf full", rdy[0], 0);
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    check_eq("abort out", sout[0], 0);
    check_eq("abort ov", oval[0], 0);
    check_eq("abort busy", bsy[0], 0);
    check_eq("abort rdy", rdy[0], 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq($sformatf("abort done c%0d", c), dn[0], 0);
      check_eq($sformatf("abort ov c%0d", c), oval[0], 0);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    check_eq("post busy", bsy[0], 0);
    check_eq("post rdy", rdy[0], 1);
    check_eq("post ov", oval[0], 0);
    din[0] = 8'hFF;
    vld[0] = 1'b1;
    tick();
    vld[0] = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      check_eq($sformatf("ff out c%0d", c), sout[0], 1);
      check_eq($sformatf("ff ov c%0d", c), oval[0], (c <= 8));
      check_eq($sformatf("ff done c%0d", c), dn[0], (c == 8));
      tick();
    end

    // random words with random gaps on all configurations
    mon_en = 1'b1;
    fork
      drive_rand(0);
      drive_rand(1);
      drive_rand(2);
      drive_rand(3);
    join
    begin
      int guard;
      guard = 0;
      while (bsy != 4'h0 && guard < 200) begin
        tick();
        guard++;
      end
      check_eq("rand drain", bsy, 4'h0);
    end
    tick();
    mon_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("rand frames i%0d", i), ndone[i], 50);
      check_eq($sformatf("rand leftover i%0d", i), expq[i].size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
